// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serial transmitter family.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned GAP_CNT_W = 4;

  // Position in the word register of the bit that goes out next.
  function automatic int unsigned next_bit_idx(input bit msb_first, input int unsigned width);
    return msb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Parallel-to-serial transmitter: valid/ready word in, one registered bit per clock out,
// with an end-of-word strobe and an optional idle gap between words.
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             d_out,
  output logic             d_out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam int unsigned          OUT_IDX  = next_bit_idx(MSB_FIRST, WIDTH);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     PREV_CNT = CNT_W'(WIDTH - 2);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   d_out_q, d_out_d;
  logic                   d_out_valid_q, d_out_valid_d;
  logic                   word_done_q, word_done_d;
  logic                   last_bit;
  logic                   accept;

  // Move the remaining bits toward the output position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  assign din_ready = !reset && ((state_q == ST_IDLE) || ((GAP == 0) && last_bit));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    d_out_d       = 1'b0;
    d_out_valid_d = 1'b0;
    word_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d       = ST_SHIFT;
          cnt_d         = '0;
          d_out_d       = din[OUT_IDX];
          shreg_d       = shift_word(din);
          d_out_valid_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          cnt_d         = cnt_q + 1'b1;
          d_out_d       = shreg_q[OUT_IDX];
          shreg_d       = shift_word(shreg_q);
          d_out_valid_d = 1'b1;
          word_done_d   = (cnt_q == PREV_CNT);
        end else if (accept) begin
          // Back-to-back load: first bit of the next word follows with no bubble.
          cnt_d         = '0;
          d_out_d       = din[OUT_IDX];
          shreg_d       = shift_word(din);
          d_out_valid_d = 1'b1;
        end else if (GAP != 0) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      d_out_q       <= 1'b0;
      d_out_valid_q <= 1'b0;
      word_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      d_out_q       <= d_out_d;
      d_out_valid_q <= d_out_valid_d;
      word_done_q   <= word_done_d;
    end
  end

  assign d_out       = d_out_q;
  assign d_out_valid = d_out_valid_q;
  assign word_done   = word_done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: four configurations, bit scoreboard, downstream register model.
module tb_nibble_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] din         [4];
  logic       din_valid   [4];
  logic       din_ready   [4];
  logic       d_out       [4];
  logic       d_out_valid [4];
  logic       word_done   [4];
  logic       busy        [4];
  logic [3:0] ds_q;

  int   vectors    = 0;
  int   miscompares = 0;
  logic sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(1)) u_msb (
    .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .d_out(d_out[0]), .d_out_valid(d_out_valid[0]), .word_done(word_done[0]), .busy(busy[0]));

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(1)) u_lsb (
    .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .d_out(d_out[1]), .d_out_valid(d_out_valid[1]), .word_done(word_done[1]), .busy(busy[1]));

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u_b2b (
    .clk(clk), .reset(reset), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .d_out(d_out[2]), .d_out_valid(d_out_valid[2]), .word_done(word_done[2]), .busy(busy[2]));

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u_stall (
    .clk(clk), .reset(reset), .din(din[3]), .din_valid(din_valid[3]), .din_ready(din_ready[3]),
    .d_out(d_out[3]), .d_out_valid(d_out_valid[3]), .word_done(word_done[3]), .busy(busy[3]));

  // Downstream 4-bit left-shifting serial-in register fed by the MSB-first instance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ds_q <= 4'h0;
    else if (d_out_valid[0]) ds_q <= {ds_q[2:0], d_out[0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs);
    logic e;
    if (sb.size() != 0) e = sb.pop_front();
    else e = ~obs;
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic push_word(input logic [3:0] w, input bit msb);
    for (int b = 0; b < 4; b++) sb.push_back(msb ? w[2'(3 - b)] : w[2'(b)]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i]       = 4'h0;
      din_valid[i] = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_d_out",     32'(d_out[0]),       0);
    chk("rst_valid",     32'(d_out_valid[0]), 0);
    chk("rst_word_done", 32'(word_done[0]),   0);
    chk("rst_busy",      32'(busy[0]),        0);
    chk("rst_ready",     32'(din_ready[0]),   0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(din_ready[0]), 1);

    // Single word, MSB first, GAP=1
    din[0] = 4'b1011;
    din_valid[0] = 1'b1;
    push_word(4'b1011, 1'b1);
    step();
    din_valid[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      chk("t1_ready", 32'(din_ready[0]), 32'(k == 6));
      chk("t1_valid", 32'(d_out_valid[0]), 32'(k <= 4));
      if (k <= 4) chk_bit("t1_bit", d_out[0]);
      chk("t1_done", 32'(word_done[0]), 32'(k == 4));
    end
    chk("t1_downstream", 32'(ds_q), 32'hB);

    // LSB first
    din[1] = 4'b1011;
    din_valid[1] = 1'b1;
    push_word(4'b1011, 1'b0);
    step();
    din_valid[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      chk("t2_valid", 32'(d_out_valid[1]), 32'(k <= 4));
      if (k <= 4) chk_bit("t2_bit", d_out[1]);
      chk("t2_done", 32'(word_done[1]), 32'(k == 4));
    end

    // Back-to-back with GAP=0
    din[2] = 4'hA;
    din_valid[2] = 1'b1;
    push_word(4'hA, 1'b1);
    step();
    din[2] = 4'h5;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step();
      if (k == 5) din_valid[2] = 1'b0;
      if (k == 2) chk("t3_ready_mid", 32'(din_ready[2]), 0);
      if (k == 4) begin
        chk("t3_ready_last", 32'(din_ready[2]), 1);
        push_word(4'h5, 1'b1);
      end
      chk("t3_valid", 32'(d_out_valid[2]), 32'(k <= 8));
      if (k <= 8) chk_bit("t3_bit", d_out[2]);
      chk("t3_done", 32'(word_done[2]), 32'(k == 4 || k == 8));
    end

    // Stall: request during SHIFT, accepted only once back in IDLE
    din[3] = 4'hC;
    din_valid[3] = 1'b1;
    push_word(4'hC, 1'b1);
    step();
    din_valid[3] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      if (k == 2) begin
        din[3] = 4'h3;
        din_valid[3] = 1'b1;
      end
      if (k == 5) din[3] = 4'hE;
      if (k == 8) din_valid[3] = 1'b0;
      chk("t4_ready", 32'(din_ready[3]), 32'(k == 7));
      if (k == 7) push_word(4'hE, 1'b1);
      chk("t4_valid", 32'(d_out_valid[3]), 32'(k <= 4 || (k >= 8 && k <= 11)));
      if (d_out_valid[3]) chk_bit("t4_bit", d_out[3]);
      chk("t4_done", 32'(word_done[3]), 32'(k == 4 || k == 11));
      chk("t4_busy", 32'(busy[3]), 32'(k != 7));
    end
    step();
    step();

    // Asynchronous reset during the second bit of a word
    din[0] = 4'hC;
    din_valid[0] = 1'b1;
    step();
    din_valid[0] = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("t5_d_out",  32'(d_out[0]),       0);
    chk("t5_valid",  32'(d_out_valid[0]), 0);
    chk("t5_done",   32'(word_done[0]),   0);
    chk("t5_busy",   32'(busy[0]),        0);
    chk("t5_ready",  32'(din_ready[0]),   0);
    #2 reset = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      step();
      chk("t5_no_done",  32'(word_done[0]),   0);
      chk("t5_no_valid", 32'(d_out_valid[0]), 0);
      chk("t5_idle",     32'(din_ready[0]),   1);
    end
    din[0] = 4'h6;
    din_valid[0] = 1'b1;
    push_word(4'h6, 1'b1);
    step();
    din_valid[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      chk("t5_valid_after", 32'(d_out_valid[0]), 1);
      chk_bit("t5_bit", d_out[0]);
      chk("t5_done_after", 32'(word_done[0]), 32'(k == 4));
    end
    step();
    step();

    // End-to-end into the downstream register
    din[0] = 4'h9;
    din_valid[0] = 1'b1;
    push_word(4'h9, 1'b1);
    step();
    din_valid[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      if (k <= 4) chk_bit("t6_bit", d_out[0]);
      chk("t6_done", 32'(word_done[0]), 32'(k == 4));
      if (k == 5) chk("t6_downstream", 32'(ds_q), 32'h9);
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
